pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
- Next-generation pipelined main control for the 5-stage RISC-V core.
- Decodes the ID-stage opcode into a control bundle covering the R, I-ALU, load, store, branch, JAL, JALR and LUI classes.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, applies branch/jump flushes and memory freezes, and keeps saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5: register-index width.
- ALUOP_W, 2: ALUop width.
- CNT_W, 16: width of each performance counter.
- EN_EXT, 1: when 1, decode JAL/JALR/LUI/I-ALU; when 0, those opcodes are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  the ID-stage instruction is valid.
- id_opcode  in  7  ID instruction bits [6:0].
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  ID register indices.
- ex_redirect  in  1  EX resolved a taken branch or a jump.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- pc_write  out  1  IF may advance the PC; low means hold.
- ifid_write  out  1  IF/ID may load; low means hold.
- ifid_flush  out  1  clear IF/ID to a bubble.
- id_illegal  out  1  combinational; id_valid high with an undecodable opcode.
- ex_valid, ex_alusrc, ex_branch, ex_jump  out  1 each  ID/EX control.
- ex_aluop  out  ALUOP_W  ID/EX control.
- ex_rd  out  REG_ADDR_W  ID/EX destination.
- mem_valid, mem_read, mem_write  out  1 each  EX/MEM control.
- mem_rd  out  REG_ADDR_W  EX/MEM destination.
- wb_valid, wb_regwrite  out  1 each  MEM/WB control.
- wb_memtoreg  out  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- wb_rd  out  REG_ADDR_W  MEM/WB destination.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Behaviour:
- Decode is combinational on id_opcode and lists every field for every opcode. Fields not listed below are 0.
  - 0110011 R: regwrite=1, aluop=10, uses rs1 and rs2.
  - 0010011 I-ALU: alusrc=1, regwrite=1, aluop=11, uses rs1.
  - 0000011 load: alusrc=1, read=1, regwrite=1, memtoreg=01, aluop=00, uses rs1.
  - 0100011 store: alusrc=1, write=1, aluop=00, uses rs1 and rs2.
  - 1100011 branch: branch=1, aluop=01, uses rs1 and rs2.
  - 1101111 JAL: jump=1, regwrite=1, memtoreg=10.
  - 1100111 JALR: jump=1, alusrc=1, regwrite=1, memtoreg=10, aluop=00, uses rs1.
  - 0110111 LUI: alusrc=1, regwrite=1, memtoreg=11.
  - Any other opcode: all fields 0 and id_illegal=1. The instruction enters ID/EX as a bubble.
- regwrite is forced to 0 when rd==0. The stage is still valid.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)) & id_valid.
- Priority each cycle: mem_busy > ex_redirect > load-use > normal.
  - mem_busy: every stage register holds, pc_write=0, ifid_write=0, ifid_flush=0, no counter change.
  - ex_redirect (mem_busy=0): a bubble (all zero) loads into ID/EX, ifid_flush=1, pc_write=1, flush_cnt increments. A load-use hazard in the same cycle is ignored because its instruction is squashed.
  - load-use: a bubble loads into ID/EX, pc_write=0, ifid_write=0, stall_cnt increments. The hazard clears the next cycle, giving exactly one bubble per hazard.
  - normal: the decoded bundle loads into ID/EX, gated by id_valid. EX→MEM and MEM→WB advance every non-frozen cycle.
- Latency: ID decode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Counters saturate at all-ones and never wrap.
- Reset (asynchronous, any time, including mid-stall): every stage register clears to 0, valids 0, both counters 0. Outputs then read pc_write=1, ifid_write=1, ifid_flush=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI);
  - ALUop encodings and WB_SEL encodings;
  - the packed ctrl_t bundle struct and the bubble constant.
- One sub-module, ctrl_decode: the combinational opcode → ctrl_t mapping plus uses_rs1/uses_rs2 and illegal.
- Hazard logic, stage registers and counters stay in pipe_ctrl_unit.

Test Plan:
- Reset, then 0110011 rd=5 with id_valid → ex_aluop=10 at +1, mem_valid at +2, wb_regwrite=1, wb_memtoreg=00, wb_rd=5 at +3.
- Load rd=3, then R using rs1=3 → one bubble: ex_valid=0 for one cycle, pc_write=0 and ifid_write=0 for one cycle, stall_cnt=1; the R instruction reaches EX on the next cycle.
- Load rd=0, then R using rs1=0 → no stall; load wb_regwrite=0.
- Branch in EX with ex_redirect=1 while ID holds a load-use hazard → ifid_flush=1, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- mem_busy=1 for 3 cycles mid-stream → all ex_/mem_/wb_ outputs stable, pc_write=0, counters unchanged; the pipeline resumes afterwards.
- Opcode 1111111 → id_illegal=1, bubble loaded. With EN_EXT=0, opcode 1101111 → id_illegal=1.
- Counter saturation: force 2^CNT_W+2 hazards with CNT_W=4 → stall_cnt holds 15.
- Assert rst_n low mid-stall → all outputs clear asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined main control: opcodes, ALUop and
// write-back select encodings, the control bundle and the per-cycle pipeline action.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic       regwrite;
    logic [1:0] memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Freeze outranks flush, which outranks a load-use stall.
  typedef enum logic [1:0] {
    ActNormal,
    ActStall,
    ActFlush,
    ActFreeze
  } pipe_act_e;

  // Opcodes that are only legal when the extended decode is enabled.
  function automatic logic is_ext_op(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into the control bundle, plus source-register
// usage flags and the illegal-opcode indication.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned EN_EXT = 1
) (
  input  logic [6:0] i_opcode,
  input  logic       i_rd_zero,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_illegal
);

  ctrl_t w_ctrl;
  logic  w_uses_rs1;
  logic  w_uses_rs2;
  logic  w_illegal;

  always_comb begin
    w_ctrl     = CTRL_BUBBLE;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_illegal  = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_FUNCT;
        w_uses_rs1      = 1'b1;
        w_uses_rs2      = 1'b1;
      end
      OP_IMM: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_IMM;
        w_uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = WB_SEL_MEM;
        w_ctrl.aluop    = ALUOP_ADD;
        w_uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.alusrc    = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.aluop     = ALUOP_ADD;
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.aluop  = ALUOP_BRANCH;
        w_uses_rs1    = 1'b1;
        w_uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.jump     = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = WB_SEL_PC4;
      end
      OP_JALR: begin
        w_ctrl.jump     = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = WB_SEL_PC4;
        w_ctrl.aluop    = ALUOP_ADD;
        w_uses_rs1      = 1'b1;
      end
      OP_LUI: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = WB_SEL_IMM;
      end
      default: w_illegal = 1'b1;
    endcase

    if ((EN_EXT == 0) && is_ext_op(i_opcode)) begin
      w_ctrl     = CTRL_BUBBLE;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      w_illegal  = 1'b1;
    end

    // x0 is never written; the instruction itself still flows as valid.
    if (i_rd_zero) begin
      w_ctrl.regwrite = 1'b0;
    end
  end

  assign o_ctrl     = w_ctrl;
  assign o_uses_rs1 = w_uses_rs1;
  assign o_uses_rs2 = w_uses_rs2;
  assign o_illegal  = w_illegal;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use stall, redirect flush, memory freeze and saturating event counters.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EN_EXT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_id_valid,
  input  logic [6:0]            i_id_opcode,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_ex_redirect,
  input  logic                  i_mem_busy,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_id_illegal,
  output logic                  o_ex_valid,
  output logic                  o_ex_alusrc,
  output logic                  o_ex_branch,
  output logic                  o_ex_jump,
  output logic [ALUOP_W-1:0]    o_ex_aluop,
  output logic [REG_ADDR_W-1:0] o_ex_rd,
  output logic                  o_mem_valid,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [REG_ADDR_W-1:0] o_mem_rd,
  output logic                  o_wb_valid,
  output logic                  o_wb_regwrite,
  output logic [1:0]            o_wb_memtoreg,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t     w_dec;
  logic      w_uses_rs1;
  logic      w_uses_rs2;
  logic      w_dec_illegal;
  logic      w_rd_zero;
  logic      w_load_use;
  pipe_act_e w_act;

  ctrl_t                 w_ex_ctrl_d;
  logic                  w_ex_valid_d;
  logic [REG_ADDR_W-1:0] w_ex_rd_d;

  // ID/EX
  logic                  r_ex_valid;
  ctrl_t                 r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  // EX/MEM
  logic                  r_mem_valid;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_regwrite;
  logic [1:0]            r_mem_memtoreg;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  // MEM/WB
  logic                  r_wb_valid;
  logic                  r_wb_regwrite;
  logic [1:0]            r_wb_memtoreg;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_rd_zero = (i_id_rd == '0);

  ctrl_decode #(
    .EN_EXT (EN_EXT)
  ) u_decode (
    .i_opcode   (i_id_opcode),
    .i_rd_zero  (w_rd_zero),
    .o_ctrl     (w_dec),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_dec_illegal)
  );

  always_comb begin
    w_load_use = i_id_valid && r_ex_valid && r_ex_ctrl.mem_read && (r_ex_rd != '0) &&
                 ((w_uses_rs1 && (i_id_rs1 == r_ex_rd)) ||
                  (w_uses_rs2 && (i_id_rs2 == r_ex_rd)));
  end

  always_comb begin
    if (i_mem_busy) begin
      w_act = ActFreeze;
    end else if (i_ex_redirect) begin
      w_act = ActFlush;
    end else if (w_load_use) begin
      w_act = ActStall;
    end else begin
      w_act = ActNormal;
    end
  end

  // Stalls, flushes and illegal opcodes all insert an all-zero bubble.
  always_comb begin
    w_ex_valid_d = (w_act == ActNormal) && i_id_valid && !w_dec_illegal;
    w_ex_ctrl_d  = w_ex_valid_d ? w_dec : CTRL_BUBBLE;
    w_ex_rd_d    = w_ex_valid_d ? i_id_rd : '0;
  end

  assign o_pc_write   = (w_act == ActNormal) || (w_act == ActFlush);
  assign o_ifid_write = (w_act == ActNormal) || (w_act == ActFlush);
  assign o_ifid_flush = (w_act == ActFlush);
  assign o_id_illegal = i_id_valid && w_dec_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_ctrl      <= CTRL_BUBBLE;
      r_ex_rd        <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= '0;
      r_mem_rd       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= '0;
      r_wb_rd        <= '0;
    end else if (w_act != ActFreeze) begin
      r_ex_valid     <= w_ex_valid_d;
      r_ex_ctrl      <= w_ex_ctrl_d;
      r_ex_rd        <= w_ex_rd_d;
      r_mem_valid    <= r_ex_valid;
      r_mem_read     <= r_ex_ctrl.mem_read;
      r_mem_write    <= r_ex_ctrl.mem_write;
      r_mem_regwrite <= r_ex_ctrl.regwrite;
      r_mem_memtoreg <= r_ex_ctrl.memtoreg;
      r_mem_rd       <= r_ex_rd;
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_rd        <= r_mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_act == ActStall) && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((w_act == ActFlush) && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_alusrc   = r_ex_ctrl.alusrc;
  assign o_ex_branch   = r_ex_ctrl.branch;
  assign o_ex_jump     = r_ex_ctrl.jump;
  assign o_ex_aluop    = ALUOP_W'(r_ex_ctrl.aluop);
  assign o_ex_rd       = r_ex_rd;
  assign o_mem_valid   = r_mem_valid;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_rd      = r_mem_rd;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_regwrite = r_wb_regwrite;
  assign o_wb_memtoreg = r_wb_memtoreg;
  assign o_wb_rd       = r_wb_rd;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule
